config_reg_sequencer: RTL
=========================

# config_reg_sequencer

Bus initiator for the `config_reg` register interface. On a `start` pulse it programs all eight configuration registers from a supplied image, then reads every register back and compares it against that image. It reports a per-register mismatch mask and an error count. It sits between the chip-level configuration controller and `config_reg`, driving `config_reg`'s write, address and data inputs and consuming its read data.

## Interface
- `NUM_REGS`, 8, number of registers walked (addresses 0..NUM_REGS-1)
- `ADDR_W`, 3, register address width
- `DATA_W`, 16, register word width
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  request a pass; sampled only in IDLE
- `verify_only`  in  1  sampled with `start`; 1 = skip the write phase
- `image`  in  NUM_REGS*DATA_W  expected/program values; slice [k*DATA_W +: DATA_W] belongs to address k; latched on start acceptance
- `busy`  out  1  high from the cycle after acceptance through the DONE cycle
- `done`  out  1  one-cycle pulse at the end of a pass
- `err_mask`  out  NUM_REGS  bit k = readback mismatch at address k
- `err_count`  out  $clog2(NUM_REGS+1)  number of mismatching registers
- `reg_write`  out  1  drives `config_reg.write`
- `reg_address`  out  ADDR_W  drives `config_reg.address`
- `reg_data_in`  out  DATA_W  drives `config_reg.data_in`
- `reg_data_out`  in  DATA_W  from `config_reg.data_out`

## Operation
- FSM states: IDLE, WRITE, RD_ADDR, RD_CAP, DONE.
- IDLE -> WRITE on `start` && !`verify_only`.
- IDLE -> RD_ADDR on `start` && `verify_only`.
- On acceptance: latch `image`; clear `err_mask` and `err_count`; set the address counter to 0.
- WRITE: `reg_write`=1, `reg_address`=k, `reg_data_in`=image[k]; one register per cycle, k = 0..NUM_REGS-1; after k = NUM_REGS-1, go to RD_ADDR with k=0.
- RD_ADDR: `reg_write`=0, `reg_address`=k.
- RD_CAP: address held at k. At the edge ending RD_CAP, capture `reg_data_out` and compare with image[k] (4-state compare, X/Z counts as a mismatch).
  - On mismatch: set err_mask[k] and increment err_count.
  - Then go to RD_ADDR with k+1, or to DONE after k = NUM_REGS-1.
- The two-cycle read tolerates either a combinational read or a one-cycle registered read in `config_reg`.
- DONE: `done`=1 for one cycle, then IDLE.
- Outside WRITE, `reg_write`=0 and `reg_data_in`=0.
- Results (`err_mask`, `err_count`) hold after DONE until the next accepted start.
- The address counter never wraps: the write phase stops at NUM_REGS-1 and never re-writes address 0.

## Timing
- Reset values: `busy`=0, `done`=0, `err_mask`=0, `err_count`=0, `reg_write`=0, `reg_address`=0, `reg_data_in`=0; state IDLE.
- `start` is accepted at edge t0. Cycles below are counted after t0.
  - Full pass: WRITE occupies cycles 1..8; read phase occupies cycles 9..24; `done` is high in cycle 25.
  - Verify-only pass: read phase occupies cycles 1..16; `done` is high in cycle 17.
  - General latency: NUM_REGS*(verify_only ? 2 : 3) + 1 cycles.
- `start` while busy, including the DONE cycle, is ignored and not queued.
- `reset` mid-pass: at the next edge all outputs take their reset values and `reg_write` drops. A partially written register set is left as is, with no rollback.
- `reset` and `start` in the same cycle: reset wins.
- `image` changes after acceptance have no effect on the current pass.

## Structure
- Shared package `config_reg_pkg` holds:
  - `reg_addr_e` (adc0_reg..digital_config, 3-bit)
  - `register_word_t` (logic [15:0])
  - `NUM_REGS`
  - the register reset-value constants (FFFF, 0000, 0000, 0000, ABCD, 0000, 0000, 0001)
  - the sequencer state enum
- No sub-module. FSM, address counter and comparator are inline.
- `config_reg` is instantiated beside this block at top level, not inside it.

## Test plan
1. Reset asserted for 2 cycles -> all outputs at their reset values; `reg_write` never rises.
2. After `config_reg` reset, `verify_only`=1 with `image` = reset constants -> 16 read cycles on addresses 0..7; `done` in cycle 17; `err_mask`=8'h00, `err_count`=0.
3. `verify_only`=0 with `image` = inverted reset values (0000, FFFF, FFFF, FFFF, 5432, FFFF, FFFF, FFFE) -> exactly 8 write cycles carrying those address/data pairs; `done` in cycle 25; `err_count`=0. A follow-up verify-only pass with the same image also gives 0.
4. Responder forced to return 16'h0000 at address 4, `image`[4]=ABCD -> `err_mask`=8'h10, `err_count`=1; all other registers pass.
5. Second `start` pulsed in cycle 5 of an active pass, and again in the DONE cycle -> both ignored; exactly one `done` pulse.
6. `reset` asserted in cycle 4 of the write phase -> next cycle `reg_write`=0, `busy`=0, addresses 4..7 not written. A new `start` then completes a full 25-cycle pass.

Source files
------------

// File: rtl/config_reg_pkg.sv
// Shared definitions for the config_reg register block and its sequencer.
//   reg_addr_e       - symbolic names for the eight register addresses
//   register_word_t  - one 16-bit register word
//   NUM_REGS         - number of registers in the block
//   *_RST            - reset value of each register
//   seq_state_e      - states of config_reg_sequencer
package config_reg_pkg;

    localparam int NUM_REGS = 8;

    typedef logic [15:0] register_word_t;

    typedef enum logic [2:0] {
        adc0_reg       = 3'd0,
        adc1_reg       = 3'd1,
        adc2_reg       = 3'd2,
        adc3_reg       = 3'd3,
        gain_reg       = 3'd4,
        offset_reg     = 3'd5,
        filter_reg     = 3'd6,
        digital_config = 3'd7
    } reg_addr_e;

    localparam register_word_t ADC0_RST           = 16'hFFFF;
    localparam register_word_t ADC1_RST           = 16'h0000;
    localparam register_word_t ADC2_RST           = 16'h0000;
    localparam register_word_t ADC3_RST           = 16'h0000;
    localparam register_word_t GAIN_RST           = 16'hABCD;
    localparam register_word_t OFFSET_RST         = 16'h0000;
    localparam register_word_t FILTER_RST         = 16'h0000;
    localparam register_word_t DIGITAL_CONFIG_RST = 16'h0001;

    typedef enum logic [2:0] {
        SEQ_IDLE    = 3'd0,
        SEQ_WRITE   = 3'd1,
        SEQ_RD_ADDR = 3'd2,
        SEQ_RD_CAP  = 3'd3,
        SEQ_DONE    = 3'd4
    } seq_state_e;

endpackage

// File: rtl/config_reg_sequencer.sv
// config_reg_sequencer: programs every config_reg register from an image,
// reads each one back and reports which registers disagree with the image.
//
// Ports
//   clk           in   single rising-edge clock
//   reset         in   synchronous, active-high
//   start         in   request a pass (only looked at while idle)
//   verify_only   in   sampled with start; 1 = read-back only, no writes
//   image         in   NUM_REGS words; word k at [k*DATA_W +: DATA_W]
//   busy          out  pass in progress (cycle after acceptance .. DONE)
//   done          out  one-cycle end-of-pass pulse
//   err_mask      out  bit k set when address k read back wrong
//   err_count     out  number of set bits in err_mask
//   reg_write     out  config_reg write strobe
//   reg_address   out  config_reg address
//   reg_data_in   out  config_reg write data
//   reg_data_out  in   config_reg read data
module config_reg_sequencer
    import config_reg_pkg::*;
#(
    parameter int NUM_REGS = config_reg_pkg::NUM_REGS,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 16,
    localparam int CNT_W   = $clog2(NUM_REGS + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         verify_only,
    input  logic [NUM_REGS*DATA_W-1:0]   image,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_REGS-1:0]          err_mask,
    output logic [CNT_W-1:0]             err_count,
    output logic                         reg_write,
    output logic [ADDR_W-1:0]            reg_address,
    output logic [DATA_W-1:0]            reg_data_in,
    input  logic [DATA_W-1:0]            reg_data_out
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    seq_state_e                   state_reg, state_next;
    logic [NUM_REGS*DATA_W-1:0]   image_reg;
    logic [ADDR_W-1:0]            addr_reg;
    logic [NUM_REGS-1:0]          err_mask_reg;
    logic [CNT_W-1:0]             err_count_reg;

    logic [DATA_W-1:0]            image_word [NUM_REGS];
    logic                         last_addr;
    logic                         rd_mismatch;

    // Split the latched image into per-address words.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_image_word
            assign image_word[gi] = image_reg[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign last_addr   = (addr_reg == LAST_ADDR);
    // Case inequality so an undriven or X read-back is flagged rather than
    // silently treated as a match.
    assign rd_mismatch = (reg_data_out !== image_word[addr_reg]);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= SEQ_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            SEQ_IDLE: begin
                if (start) begin
                    state_next = verify_only ? SEQ_RD_ADDR : SEQ_WRITE;
                end
            end
            SEQ_WRITE: begin
                if (last_addr) begin
                    state_next = SEQ_RD_ADDR;
                end
            end
            SEQ_RD_ADDR: state_next = SEQ_RD_CAP;
            SEQ_RD_CAP: begin
                state_next = last_addr ? SEQ_DONE : SEQ_RD_ADDR;
            end
            SEQ_DONE: state_next = SEQ_IDLE;
            default:  state_next = SEQ_IDLE;
        endcase
    end

    // Datapath: image latch, address counter, comparison results.
    // The counter saturates at LAST_ADDR in the read phase so it never
    // wraps back onto address 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            image_reg     <= '0;
            addr_reg      <= '0;
            err_mask_reg  <= '0;
            err_count_reg <= '0;
        end else begin
            unique case (state_reg)
                SEQ_IDLE: begin
                    if (start) begin
                        image_reg     <= image;
                        addr_reg      <= '0;
                        err_mask_reg  <= '0;
                        err_count_reg <= '0;
                    end
                end
                SEQ_WRITE: begin
                    addr_reg <= last_addr ? '0 : addr_reg + 1'b1;
                end
                SEQ_RD_CAP: begin
                    if (rd_mismatch) begin
                        err_mask_reg[addr_reg] <= 1'b1;
                        err_count_reg          <= err_count_reg + 1'b1;
                    end
                    if (!last_addr) begin
                        addr_reg <= addr_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the registered state; reset forces IDLE, so all
    // bus outputs fall to zero on the edge that samples reset.
    always_comb begin
        busy        = (state_reg != SEQ_IDLE);
        done        = (state_reg == SEQ_DONE);
        reg_write   = 1'b0;
        reg_address = '0;
        reg_data_in = '0;
        unique case (state_reg)
            SEQ_WRITE: begin
                reg_write   = 1'b1;
                reg_address = addr_reg;
                reg_data_in = image_word[addr_reg];
            end
            SEQ_RD_ADDR, SEQ_RD_CAP: begin
                reg_address = addr_reg;
            end
            default: ;
        endcase
    end

    assign err_mask  = err_mask_reg;
    assign err_count = err_count_reg;

endmodule
